// File: rtl/dda_pkg.sv
// dda_pkg: opcodes, scheduler states and reset constants shared by the DDA control slice
package dda_pkg;
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WR_ICX = 3'd1;
    localparam logic [2:0] OP_WR_ICY = 3'd2;
    localparam logic [2:0] OP_WR_MU  = 3'd3;
    localparam logic [2:0] OP_WR_DIV = 3'd4;
    localparam logic [2:0] OP_RUN    = 3'd5;
    localparam logic [2:0] OP_STOP   = 3'd6;
    localparam logic [2:0] OP_LOAD   = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, STALL} state_t;

    localparam logic [15:0] ICX_RST = 16'h3000;
    localparam logic [15:0] ICY_RST = 16'h3000;
    localparam logic [15:0] MU_RST  = 16'h4000;
endpackage

// File: rtl/dda_sample_buf.sv
// dda_sample_buf: single-entry valid/ready holding register; a write always loads, even during a handshake
module dda_sample_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= i_wr || (o_valid && !i_ready);
            o_data  <= i_wr ? i_data : o_data;
        end
    end
endmodule

// File: rtl/dda_run_scheduler.sv
// dda_run_scheduler: turns host commands into paced DDA step/load pulses and buffers every post-step {x,y}
module dda_run_scheduler
    import dda_pkg::*;
#(
    parameter int N     = 16,
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [N-1:0]   cmd_data,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           step_en,
    output logic           load_ic,
    output logic [N-1:0]   icx,
    output logic [N-1:0]   icy,
    output logic [N-1:0]   mu,
    output logic           smp_valid,
    input  logic           smp_ready,
    output logic [2*N-1:0] smp_data,
    output logic           busy
);
    state_t           r_state, w_next;
    logic [DIV_W-1:0] r_div, r_ps;
    logic [CNT_W-1:0] r_rem;
    logic [N-1:0]     r_icx, r_icy, r_mu;
    logic             r_free, r_pend;
    logic             w_acc, w_run_cmd, w_halt, w_done, w_empty, w_tick, w_cap;

    assign w_acc     = cmd_valid && cmd_ready;
    assign w_run_cmd = w_acc && cmd_op == OP_RUN;
    assign w_halt    = w_acc && (cmd_op == OP_STOP || cmd_op == OP_LOAD);
    assign w_done    = !r_free && r_rem == '0;
    assign w_tick    = r_ps >= r_div;
    // r_pend marks a step whose result is still owed to the buffer; x,y stay put until it lands
    assign w_empty   = !smp_valid && !r_pend;
    assign w_cap     = r_pend && (!smp_valid || smp_ready);
    assign icx       = r_icx;
    assign icy       = r_icy;
    assign mu        = r_mu;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_acc && cmd_op == OP_LOAD) ? LOAD : w_run_cmd ? RUN : IDLE;
            LOAD:    w_next = IDLE;
            RUN:     w_next = w_done ? ((r_pend && !w_cap) ? RUN : IDLE)
                                     : (w_tick && !step_en) ? STALL : RUN;
            STALL:   w_next = step_en ? RUN : STALL;
            default: w_next = IDLE;
        endcase
        if (r_state == RUN || r_state == STALL)
            w_next = (w_acc && cmd_op == OP_LOAD) ? LOAD :
                     (w_acc && cmd_op == OP_STOP) ? IDLE :
                     w_run_cmd ? RUN : w_next;
    end

    // A step may only fire when its sample is guaranteed a slot the following cycle
    always_comb begin
        step_en   = (r_state == RUN && !w_done && w_tick && (smp_ready || w_empty)) ||
                    (r_state == STALL && w_empty);
        load_ic   = r_state == LOAD;
        busy      = r_state != IDLE;
        cmd_ready = r_state != LOAD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_icx  <= N'(ICX_RST);
            r_icy  <= N'(ICY_RST);
            r_mu   <= N'(MU_RST);
            r_div  <= '0;
            r_ps   <= '0;
            r_rem  <= '0;
            r_free <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (w_acc && cmd_op == OP_WR_ICX) r_icx <= cmd_data;
            if (w_acc && cmd_op == OP_WR_ICY) r_icy <= cmd_data;
            if (w_acc && cmd_op == OP_WR_MU)  r_mu  <= cmd_data;
            if (w_acc && cmd_op == OP_WR_DIV) r_div <= cmd_data[DIV_W-1:0];
            r_pend <= step_en || (r_pend && !w_cap);
            if (w_run_cmd) begin
                r_rem  <= cmd_data[CNT_W-1:0];
                r_free <= cmd_data[CNT_W-1:0] == '0;
                r_ps   <= '0;
            end else if (w_halt) begin
                r_rem  <= '0;
                r_free <= 1'b0;
            end else begin
                if (step_en && !r_free && r_rem != '0) r_rem <= r_rem - CNT_W'(1);
                if (step_en) r_ps <= '0;
                else if (r_state == RUN && !w_tick) r_ps <= r_ps + DIV_W'(1);
            end
        end
    end

    dda_sample_buf #(.W(2*N)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_cap),
        .i_data  ({x, y}),
        .i_ready (smp_ready),
        .o_valid (smp_valid),
        .o_data  (smp_data)
    );
endmodule

// File: doc/dda_run_scheduler.md
Name: dda_run_scheduler

Overview:
Sequences the posit Van der Pol DDA core from host commands so the core no longer relies on clock toggling at SPI chip-select edges. It holds the system parameters (icx, icy, mu) and a step-rate divider. It issues single-cycle step enables at a programmable rate, for a bounded or unbounded step count. It captures every post-step {x,y} into a one-entry sample buffer with valid/ready backpressure. It sits between the SPI command decoder (upstream) and the dda core plus SPI readout (downstream).

Parameters:
N, 16, posit word width of x, y, icx, icy, mu
DIV_W, 16, width of the step-rate divider
CNT_W, 16, width of the step-count budget

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command strobe from SPI decoder
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  opcode: 0 NOP, 1 WR_ICX, 2 WR_ICY, 3 WR_MU, 4 WR_DIV, 5 RUN, 6 STOP, 7 LOAD
cmd_data  in  N  operand (DIV uses low DIV_W bits; RUN uses low CNT_W bits as step count)
x  in  N  DDA state x, valid the cycle after step_en
y  in  N  DDA state y, valid the cycle after step_en
step_en  out  1  one-cycle DDA advance enable
load_ic  out  1  one-cycle pulse: DDA reloads x,y from icx,icy
icx  out  N  initial condition x
icy  out  N  initial condition y
mu  out  N  Van der Pol parameter
smp_valid  out  1  sample buffer full
smp_ready  in  1  consumer takes sample when valid&ready
smp_data  out  2N  {x,y} captured after a step
busy  out  1  high in LOAD, RUN, STALL

Behaviour:
- Reset (rst_n low at posedge): state IDLE; icx=icy=16'h3000; mu=16'h4000; div=0; remaining=0; free_run=0; step_en=load_ic=0; smp_valid=0; smp_data=0; prescale counter=0.
- Reset applied mid-run: same values next cycle; any pending sample is discarded.
- Parameter writes:
  - WR_ICX, WR_ICY, WR_MU and WR_DIV take effect the cycle after acceptance, in any state.
  - A mu write during RUN affects the next step (live sweep).
  - icx/icy writes reach the core only at the next LOAD.
- cmd_ready=1 in all states except LOAD.
- States:
  - IDLE: load_ic, step_en low. LOAD -> LOAD. RUN -> RUN, with prescaler cleared, remaining=cmd_data and free_run=(cmd_data==0). STOP and NOP are no-ops.
  - LOAD: load_ic=1 for exactly one cycle, then return to IDLE. A LOAD received in RUN or STALL also goes to LOAD; the run is aborted and remaining is cleared.
  - RUN: prescaler counts 0..div; on reaching div, step_en=1 for one cycle and prescaler wraps to 0. Step period = div+1 cycles; div=0 steps every cycle.
    - On a step with !free_run, remaining decrements.
    - When remaining reaches 0 with !free_run, go to IDLE after that step's sample is captured.
  - STALL: entered instead of issuing a step when the step would fire while smp_valid=1 and no handshake occurs that cycle. Prescaler holds at div. The step issues the cycle after the buffer empties, then the state returns to RUN. No sample is ever dropped.
- STOP in RUN or STALL: go to IDLE next cycle. A step_en in the same cycle as STOP acceptance still completes and is sampled. remaining is cleared.
- RUN received while already in RUN or STALL restarts the budget and prescaler.
- Sampling:
  - Step at cycle t; smp_data={x,y} registered at end of t+1; smp_valid=1 from t+2.
  - smp_valid clears the cycle after valid&ready.
  - Capture and handshake in the same cycle: new data is loaded and valid stays 1.
- Arithmetic: prescaler and remaining are unsigned, with no wrap below 0.

Decomposition:
- Shared package dda_pkg holds:
  - cmd_op encodings (OP_NOP..OP_LOAD);
  - the state enum {IDLE, LOAD, RUN, STALL};
  - reset constants ICX_RST, ICY_RST, MU_RST.
- One sub-module: dda_sample_buf (single-entry valid/ready register, 2N wide), also reusable by SPI readout.
- The prescaler stays inline.

Test Plan:
- Reset, then LOAD -> load_ic pulses exactly 1 cycle; icx=icy=16'h3000 and mu=16'h4000 held; busy high that cycle only.
- WR_DIV 3, RUN 5 with smp_ready=1 -> exactly 5 step_en pulses, 4 cycles apart; 5 samples, each valid 2 cycles after its step; then IDLE, busy=0.
- WR_DIV 0, RUN 0 (free-run), smp_ready held 0 -> one step, one sample, STALL with no further steps. Raising smp_ready -> next step 1 cycle after the handshake. Sample count always equals step count.
- During free-run, WR_MU 16'h5000 -> mu updates next cycle with no interruption of the step cadence. STOP -> IDLE; the step coinciding with STOP is still sampled.
- RUN 10, assert rst_n=0 after step 4 -> all outputs at reset values next cycle; smp_valid=0; no further step_en.
- Capture and handshake in the same cycle -> smp_data holds the new sample and smp_valid stays 1.
